// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite row fetch path.
package sprite_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } orient_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  localparam logic [3:0] EMPTY_SPRITE = 4'hF;
  localparam int         TILE_W       = 8;

endpackage

// File: rtl/sprite_line_buffer.sv
// Double-buffered tile line store: writes land in the back bank, pixel reads come from the front bank.
module sprite_line_buffer
  import sprite_pkg::*;
#(
  parameter int TILES = 10,
  parameter int CW    = $clog2(TILES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              front_bank,
  input  logic              wr_en,
  input  logic [CW-1:0]     wr_col,
  input  logic [TILE_W-1:0] wr_data,
  input  logic [CW-1:0]     rd_col,
  input  logic [2:0]        rd_x,
  output logic              pixel_on
);

  logic [TILE_W-1:0] mem [2][TILES];
  logic              back_bank;
  logic              rd_in_range;

  assign back_bank   = ~front_bank;
  assign rd_in_range = ({1'b0, rd_col} < (CW+1)'(TILES));

  // Stored slices are active-low; an erased entry (all ones) reads as blank.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int t = 0; t < TILES; t++) begin
          mem[b][t] <= '1;
        end
      end
      pixel_on <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[back_bank][wr_col] <= wr_data;
      end
      pixel_on <= rd_in_range ? ~mem[front_bank][rd_col][rd_x] : 1'b0;
    end
  end

endmodule

// File: rtl/sprite_row_fetcher.sv
// Per-scanline scheduler: walks the tile map, forwards each tile to the sprite ROM and
// captures the returned slice into the back bank of the line buffer.
//
//   state | meaning
//   IDLE  | back bank complete, waiting for line_start
//   FETCH | issuing map requests / draining the 2-stage map->ROM pipeline
module sprite_row_fetcher
  import sprite_pkg::*;
#(
  parameter  int TILES = 10,
  localparam int CW    = $clog2(TILES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_start,
  input  logic [2:0]    line_index,
  output logic [CW-1:0] map_col,
  output logic          map_req,
  input  logic [3:0]    map_sprite_ID,
  input  logic [1:0]    map_orientation,
  output logic [3:0]    rom_sprite_ID,
  output logic [1:0]    rom_orientation,
  output logic [2:0]    rom_line_index,
  input  logic [7:0]    rom_data,
  input  logic [CW-1:0] pix_col,
  input  logic [2:0]    pix_x,
  output logic          pixel_on,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  fetch_state_t  state, next_state;
  logic          front_bank;
  logic [2:0]    line_idx_q;
  logic          req_d1, req_d2;
  logic [CW-1:0] col_d1, col_d2;
  logic          last_col;
  logic          wr_en;
  logic          last_wr;

  assign last_col = (map_col == CW'(TILES - 1));
  // A new line_start discards the write that would land in the same cycle.
  assign wr_en    = req_d2 && !line_start;
  assign last_wr  = wr_en && (col_d2 == CW'(TILES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (line_start) next_state = FETCH;
      FETCH: begin
        if (line_start)   next_state = FETCH;
        else if (last_wr) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy            = (state == FETCH);
    overrun         = line_start && (state == FETCH) && !reset;
    rom_sprite_ID   = EMPTY_SPRITE;
    rom_orientation = UP;
    if (req_d1) begin
      rom_sprite_ID   = map_sprite_ID;
      rom_orientation = map_orientation;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      map_col    <= '0;
      map_req    <= 1'b0;
      req_d1     <= 1'b0;
      req_d2     <= 1'b0;
      col_d1     <= '0;
      col_d2     <= '0;
      front_bank <= 1'b0;
      line_idx_q <= '0;
      done       <= 1'b0;
    end else begin
      done <= last_wr;
      if (line_start) begin
        front_bank <= ~front_bank;
        line_idx_q <= line_index;
        map_col    <= '0;
        map_req    <= 1'b1;
        req_d1     <= 1'b0;
        req_d2     <= 1'b0;
      end else begin
        if (map_req) begin
          if (last_col) map_req <= 1'b0;
          else          map_col <= map_col + CW'(1);
        end
        req_d1 <= map_req;
        col_d1 <= map_col;
        req_d2 <= req_d1;
        col_d2 <= col_d1;
      end
    end
  end

  assign rom_line_index = line_idx_q;

  sprite_line_buffer #(
    .TILES (TILES),
    .CW    (CW)
  ) u_line_buffer (
    .clk        (clk),
    .reset      (reset),
    .front_bank (front_bank),
    .wr_en      (wr_en),
    .wr_col     (col_d2),
    .wr_data    (rom_data),
    .rd_col     (pix_col),
    .rd_x       (pix_x),
    .pixel_on   (pixel_on)
  );

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Directed bench for sprite_row_fetcher with a tile-map model and a small sprite ROM model.
module tb_sprite_row_fetcher;
  import sprite_pkg::*;

  localparam int TILES = 10;
  localparam int CW    = $clog2(TILES);

  logic          clk;
  logic          reset;
  logic          line_start;
  logic [2:0]    line_index;
  logic [CW-1:0] map_col;
  logic          map_req;
  logic [3:0]    map_sprite_ID;
  logic [1:0]    map_orientation;
  logic [3:0]    rom_sprite_ID;
  logic [1:0]    rom_orientation;
  logic [2:0]    rom_line_index;
  logic [7:0]    rom_data;
  logic [CW-1:0] pix_col;
  logic [2:0]    pix_x;
  logic          pixel_on;
  logic          busy;
  logic          done;
  logic          overrun;

  logic [3:0] tbl_id  [TILES];
  logic [1:0] tbl_ori [TILES];

  int checks   = 0;
  int failures = 0;

  sprite_row_fetcher #(.TILES(TILES)) dut (
    .clk             (clk),
    .reset           (reset),
    .line_start      (line_start),
    .line_index      (line_index),
    .map_col         (map_col),
    .map_req         (map_req),
    .map_sprite_ID   (map_sprite_ID),
    .map_orientation (map_orientation),
    .rom_sprite_ID   (rom_sprite_ID),
    .rom_orientation (rom_orientation),
    .rom_line_index  (rom_line_index),
    .rom_data        (rom_data),
    .pix_col         (pix_col),
    .pix_x           (pix_x),
    .pixel_on        (pixel_on),
    .busy            (busy),
    .done            (done),
    .overrun         (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sprite ROM contents (active-low, bit x = pixel x).
  function automatic logic [7:0] rom_fn(input logic [3:0] id, input logic [1:0] ori,
                                        input logic [2:0] li);
    case (id)
      4'd0:    rom_fn = (li == 3'd3) ? 8'b1110_1011 : 8'h3C;
      4'd1:    rom_fn = 8'b1111_0111;
      4'd2:    rom_fn = (ori == 2'd3) ? 8'hF0 : 8'h0F;
      default: rom_fn = 8'hFF;
    endcase
  endfunction

  initial begin
    map_sprite_ID   = 4'hF;
    map_orientation = 2'd0;
    rom_data        = 8'hFF;
  end

  always @(posedge clk) begin
    if (map_req) begin
      map_sprite_ID   <= tbl_id[map_col];
      map_orientation <= tbl_ori[map_col];
    end
    rom_data <= rom_fn(rom_sprite_ID, rom_orientation, rom_line_index);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [2:0] idx, input logic exp_ovr, input string tag);
    line_start = 1'b1;
    line_index = idx;
    #1;
    check_eq(tag, overrun, exp_ovr);
    tick;
    line_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    check_eq(tag, n, TILES + 3);
  endtask

  task automatic check_col(input int col, input logic [7:0] slice, input string tag);
    for (int x = 0; x < 8; x++) begin
      pix_col = CW'(col);
      pix_x   = 3'(x);
      tick;
      check_eq(tag, pixel_on, !slice[x]);
    end
  endtask

  task automatic fill_table(input logic [3:0] id, input logic [1:0] ori);
    for (int c = 0; c < TILES; c++) begin
      tbl_id[c]  = id;
      tbl_ori[c] = ori;
    end
  endtask

  initial begin
    reset      = 1'b1;
    line_start = 1'b0;
    line_index = 3'd0;
    pix_col    = '0;
    pix_x      = 3'd0;
    fill_table(4'hF, 2'd0);
    repeat (3) tick;
    reset = 1'b0;

    check_eq("rst_map_req", map_req, 0);
    check_eq("rst_map_col", map_col, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_rom_id", rom_sprite_ID, 4'hF);
    check_eq("rst_rom_ori", rom_orientation, 0);
    check_eq("rst_rom_li", rom_line_index, 0);
    check_eq("rst_pixel", pixel_on, 0);
    for (int c = 0; c < TILES; c++) check_col(c, 8'hFF, "rst_read");

    // Heart fetch with cycle-exact timing checks.
    for (int c = 0; c < TILES; c++) begin
      tbl_id[c]  = 4'd0;
      tbl_ori[c] = 2'(c % 4);
    end
    start_line(3'd3, 1'b0, "ovr_idle");
    for (int cyc = 1; cyc <= TILES + 3; cyc++) begin
      check_eq("t_map_req", map_req, (cyc <= TILES) ? 1 : 0);
      if (cyc <= TILES) check_eq("t_map_col", map_col, cyc - 1);
      check_eq("t_busy", busy, (cyc <= TILES + 2) ? 1 : 0);
      check_eq("t_done", done, (cyc == TILES + 3) ? 1 : 0);
      if (cyc >= 2 && cyc <= TILES + 1) begin
        check_eq("t_rom_id", rom_sprite_ID, tbl_id[cyc-2]);
        check_eq("t_rom_ori", rom_orientation, tbl_ori[cyc-2]);
      end else begin
        check_eq("t_rom_empty", rom_sprite_ID, 4'hF);
      end
      if (cyc < TILES + 3) tick;
    end
    check_eq("t_rom_li", rom_line_index, 3);
    start_line(3'd0, 1'b0, "ovr_min_gap");
    wait_done("heart2_done");
    check_col(4, 8'b1110_1011, "heart_c4");
    check_col(0, 8'b1110_1011, "heart_c0");

    // Empty sprite in column 2, sprite 1 elsewhere, over several line indices.
    fill_table(4'd1, 2'd0);
    tbl_id[2] = 4'hF;
    start_line(3'd0, 1'b0, "ovr_s1");
    wait_done("s1_done");
    for (int l = 1; l <= 6; l++) begin
      start_line(3'(l), 1'b0, "ovr_s1");
      check_eq("s1_rom_li", rom_line_index, l);
      wait_done("s1_done");
      check_col(2, 8'hFF, "s1_empty_c2");
      check_col(0, 8'b1111_0111, "s1_c0");
      check_col(TILES - 1, 8'b1111_0111, "s1_clast");
    end

    // Overrun: abort a fetch in its cycle 6.
    fill_table(4'd0, 2'd0);
    start_line(3'd3, 1'b0, "ovr_p2");
    wait_done("p2_done");
    fill_table(4'd2, 2'd0);
    start_line(3'd1, 1'b0, "ovr_p3");
    repeat (5) tick;
    start_line(3'd2, 1'b1, "ovr_pulse");
    check_eq("ovr_rom_flush", rom_sprite_ID, 4'hF);
    check_eq("ovr_map_col", map_col, 0);
    check_eq("ovr_li", rom_line_index, 2);
    wait_done("ovr_done");
    check_col(0, 8'h0F, "ovr_c0_new");
    check_col(2, 8'h0F, "ovr_c2_new");
    check_col(3, 8'b1111_0111, "ovr_c3_stale");
    check_col(TILES - 1, 8'b1111_0111, "ovr_clast_stale");

    check_col(TILES, 8'hFF, "col_oob");
    check_col(15, 8'hFF, "col_oob15");

    // Reset in cycle 4 of a fetch.
    start_line(3'd1, 1'b0, "ovr_r");
    repeat (3) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_eq("r_busy", busy, 0);
    check_eq("r_map_req", map_req, 0);
    check_eq("r_rom_id", rom_sprite_ID, 4'hF);
    check_eq("r_rom_li", rom_line_index, 0);
    begin
      int seen_done;
      seen_done = 0;
      for (int i = 0; i < 16; i++) begin
        if (done === 1'b1 || busy === 1'b1) seen_done++;
        tick;
      end
      check_eq("r_quiet", seen_done, 0);
    end
    for (int c = 0; c < TILES; c++) check_col(c, 8'hFF, "r_front");
    fill_table(4'hF, 2'd0);
    start_line(3'd0, 1'b0, "ovr_r2");
    wait_done("r2_done");
    for (int c = 0; c < TILES; c++) check_col(c, 8'hFF, "r_back");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
